serial_tx: RTL

Framed serial transmitter that sends parallel words over a single wire. It accepts a WIDTH-bit word through a valid/ready handshake and shifts it out as one start bit (0), WIDTH data bits LSB-first, and one stop bit (1). Each bit is held for CLKS_PER_BIT clocks. It is the sending end of the single-wire serial link whose receiving end samples the line with D flip-flops.

---
 rtl/serial_pkg.sv | 27 ++
 rtl/serial_tx_bit_timer.sv | 34 +++
 rtl/serial_tx.sv | 119 +++++++++++
 3 files changed

// File: rtl/serial_pkg.sv
// Shared definitions for the single-wire serial link (transmitter and receiver).
package serial_pkg;

   // Frame-level FSM states, shared by both ends of the link.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   // Line levels on the serial wire.
   localparam logic START_BIT  = 1'b0;
   localparam logic STOP_BIT   = 1'b1;
   localparam logic IDLE_LEVEL = 1'b1;

   // Width of a counter that must hold 0..n-1; never narrower than one bit
   // so that n=1 still yields a legal vector.
   function automatic int width_for(input int n);
      if (n > 1) begin
         return $clog2(n);
      end else begin
         return 1;
      end
   endfunction

endpackage : serial_pkg

// File: rtl/serial_tx_bit_timer.sv
// Bit-period timer: counts clocks within one serial bit and flags the last
// clock of each period. Shared by the transmitter and the receiver.
module bit_timer
   import serial_pkg::*;
#(
   parameter int CLKS_PER_BIT = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   output logic bit_done
);

   localparam int TW = width_for(CLKS_PER_BIT);
   localparam logic [TW-1:0] LAST_COUNT = TW'(CLKS_PER_BIT - 1);
   localparam logic [TW-1:0] ONE        = TW'(1);

   logic [TW-1:0] count;

   // Bit-period counter: restart on clear, wrap at the end of every bit.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else if (clear || bit_done) begin
         count <= '0;
      end else begin
         count <= count + ONE;
      end
   end

   // With CLKS_PER_BIT=1 the counter stays at zero and every cycle ends a bit.
   assign bit_done = (count == LAST_COUNT);

endmodule : bit_timer

// File: rtl/serial_tx.sv
// Framed serial transmitter: start bit, WIDTH data bits LSB-first, stop bit,
// each bit held for CLKS_PER_BIT clocks. Words arrive on a valid/ready handshake.
module serial_tx
   import serial_pkg::*;
#(
   parameter int WIDTH        = 8,
   parameter int CLKS_PER_BIT = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   output logic             tx,
   output logic             busy
);

   localparam int IDX_W = width_for(WIDTH);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);
   localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

   state_t             state;
   state_t             state_next;
   logic [WIDTH-1:0]   shreg;
   logic [WIDTH-1:0]   shreg_next;
   logic [WIDTH-1:0]   shreg_shifted;
   logic [IDX_W-1:0]   bit_idx;
   logic [IDX_W-1:0]   bit_idx_next;
   logic               tx_next;
   logic               timer_clear;
   logic               bit_done;

   // The timer is held at zero while idle so the start bit begins a fresh period.
   assign timer_clear   = (state == IDLE);
   assign shreg_shifted = shreg >> 1;

   bit_timer #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_bit_timer (
      .clk      (clk),
      .reset    (reset),
      .clear    (timer_clear),
      .bit_done (bit_done)
   );

   // State, data path and line registers; reset forces the line high at once.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         shreg    <= '0;
         bit_idx  <= '0;
         tx       <= IDLE_LEVEL;
         in_ready <= 1'b1;
         busy     <= 1'b0;
      end else begin
         state    <= state_next;
         shreg    <= shreg_next;
         bit_idx  <= bit_idx_next;
         tx       <= tx_next;
         in_ready <= (state_next == IDLE);
         busy     <= (state_next != IDLE);
      end
   end

   // Next-state and next-line-level decode; inputs are only looked at in IDLE.
   always_comb begin
      state_next   = state;
      shreg_next   = shreg;
      bit_idx_next = bit_idx;
      tx_next      = tx;
      case (state)
         IDLE: begin
            if (in_valid) begin
               shreg_next = in_data;
               state_next = START;
               tx_next    = START_BIT;
            end else begin
               tx_next    = IDLE_LEVEL;
            end
         end
         START: begin
            if (bit_done) begin
               state_next   = DATA;
               tx_next      = shreg[0];
               bit_idx_next = '0;
            end else begin
               tx_next      = START_BIT;
            end
         end
         DATA: begin
            if (bit_done) begin
               if (bit_idx == LAST_IDX) begin
                  state_next = STOP;
                  tx_next    = STOP_BIT;
               end else begin
                  shreg_next   = shreg_shifted;
                  bit_idx_next = bit_idx + IDX_ONE;
                  tx_next      = shreg_shifted[0];
               end
            end else begin
               tx_next = tx;
            end
         end
         STOP: begin
            if (bit_done) begin
               state_next = IDLE;
               tx_next    = IDLE_LEVEL;
            end else begin
               tx_next    = STOP_BIT;
            end
         end
         default: begin
            state_next = IDLE;
            tx_next    = IDLE_LEVEL;
         end
      endcase
   end

endmodule : serial_tx
